// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants and types for the seven-segment display path.
//   FRAME_W      width of an 8-digit frame of 5-bit digit codes, {d7,...,d0}
//   CODE_BLANK   digit code for a dark digit
//   CODE_SEG_G   digit code lighting segment g only (a dash)
//   state_t      arbiter state encoding
//   disp_t       digit frame plus decimal points, as driven to the controller
package sevenseg_pkg;

   localparam int unsigned DIGIT_W    = 5;
   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned FRAME_W    = 40;

   localparam logic [DIGIT_W-1:0] CODE_BLANK = 5'd23;
   localparam logic [DIGIT_W-1:0] CODE_SEG_G = 5'd22;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10
   } state_t;

   typedef struct packed {
      logic [FRAME_W-1:0]    digits;
      logic [NUM_DIGITS-1:0] dp;
   } disp_t;

   // Replicate one digit code across all eight digits.
   function automatic logic [FRAME_W-1:0] fill_frame(input logic [DIGIT_W-1:0] code);
      return {NUM_DIGITS{code}};
   endfunction

endpackage

// File: rtl/sevenseg_arbiter_hold_timer.sv
// hold_timer: saturating grant hold counter.
//   clk      system clock
//   reset    asynchronous active-low reset
//   clear    restart the count from 0 on the next edge
//   top_cnt  terminal count; the counter stops here
//   done     registered, high while the counter sits at top_cnt
module hold_timer #(
   parameter int unsigned CNTR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [CNTR_WIDTH-1:0] top_cnt,
   output logic                  done
);

   logic [CNTR_WIDTH-1:0] r_cnt;
   logic                  r_done;
   logic [CNTR_WIDTH-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CNTR_WIDTH'(1);

   // done is registered alongside the count so it equals (r_cnt == top_cnt).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (clear) begin
         r_cnt  <= '0;
         r_done <= (top_cnt == '0);
      end else if (r_cnt != top_cnt) begin
         r_cnt  <= w_cnt_inc;
         r_done <= (w_cnt_inc == top_cnt);
      end
   end

   assign done = r_done;

endmodule

// File: rtl/sevenseg_arbiter.sv
// sevenseg_arbiter: round-robin time-sharing of the 8-digit display between
// two requesters, with a minimum hold time per grant.
//   clk, reset        system clock, asynchronous active-low reset
//   req[1:0]          level requests, bit i = requester i
//   frame0/frame1     40-bit digit frames {d7,...,d0}, 5 bits per digit
//   dp0/dp1           decimal points, bit i = digit i
//   gnt[1:0]          one-hot grant, 0 when idle
//   d0..d7, dp        registered digit codes / decimal points to the controller
//   hold_done         high while the current grant's hold time has expired
// Build option: define SEVENSEG_ARB_IDLE_DASH_EN to show a dash row (code 22)
// instead of blank digits (code 23) while idle and in reset.
module sevenseg_arbiter
   import sevenseg_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY_HZ  = 100000000,
   parameter int unsigned HOLD_MS           = 250,
   parameter int unsigned CNTR_WIDTH        = 32,
   parameter int unsigned SIMULATE          = 0,
   parameter int unsigned SIMULATE_HOLD_CNT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req,
   input  logic [FRAME_W-1:0]    frame0,
   input  logic [FRAME_W-1:0]    frame1,
   input  logic [NUM_DIGITS-1:0] dp0,
   input  logic [NUM_DIGITS-1:0] dp1,
   output logic [1:0]            gnt,
   output logic [DIGIT_W-1:0]    d0,
   output logic [DIGIT_W-1:0]    d1,
   output logic [DIGIT_W-1:0]    d2,
   output logic [DIGIT_W-1:0]    d3,
   output logic [DIGIT_W-1:0]    d4,
   output logic [DIGIT_W-1:0]    d5,
   output logic [DIGIT_W-1:0]    d6,
   output logic [DIGIT_W-1:0]    d7,
   output logic [NUM_DIGITS-1:0] dp,
   output logic                  hold_done
);

   localparam logic [CNTR_WIDTH-1:0] TOP_CNT = (SIMULATE != 0)
      ? CNTR_WIDTH'(SIMULATE_HOLD_CNT)
      : CNTR_WIDTH'((CLK_FREQUENCY_HZ / 1000) * HOLD_MS - 1);

`ifdef SEVENSEG_ARB_IDLE_DASH_EN
   localparam logic [DIGIT_W-1:0] IDLE_CODE = CODE_SEG_G;
`else
   localparam logic [DIGIT_W-1:0] IDLE_CODE = CODE_BLANK;
`endif

   localparam disp_t IDLE_DISP = '{digits: fill_frame(IDLE_CODE), dp: '0};

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic        w_last_nxt;
   logic [1:0]  r_gnt;
   logic [1:0]  w_gnt_nxt;
   disp_t       r_disp;
   disp_t       w_disp_nxt;
   logic        w_clear;
   logic        w_hold_done;

   hold_timer #(
      .CNTR_WIDTH (CNTR_WIDTH)
   ) u_hold_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .top_cnt (TOP_CNT),
      .done    (w_hold_done)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: round-robin from IDLE, switching to the other requester
   // takes priority over staying once the hold has expired.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            case (req)
               2'b01:   w_state_nxt = ST_GRANT0;
               2'b10:   w_state_nxt = ST_GRANT1;
               2'b11:   w_state_nxt = r_last ? ST_GRANT0 : ST_GRANT1;
               default: w_state_nxt = ST_IDLE;
            endcase
         end
         ST_GRANT0: begin
            if (w_hold_done) begin
               if (req[1])      w_state_nxt = ST_GRANT1;
               else if (req[0]) w_state_nxt = ST_GRANT0;
               else             w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT1: begin
            if (w_hold_done) begin
               if (req[0])      w_state_nxt = ST_GRANT0;
               else if (req[1]) w_state_nxt = ST_GRANT1;
               else             w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output next-values, keyed on the state being entered so the frame
   // loads on the same edge that raises gnt.
   always_comb begin
      w_gnt_nxt  = 2'b00;
      w_last_nxt = r_last;
      w_disp_nxt = r_disp;
      w_clear    = (w_state_nxt != r_state) || (r_state == ST_IDLE);
      case (w_state_nxt)
         ST_GRANT0: begin
            w_gnt_nxt = 2'b01;
            if (r_state != ST_GRANT0) w_last_nxt = 1'b0;
            if (req[0]) w_disp_nxt = '{digits: frame0, dp: dp0};
         end
         ST_GRANT1: begin
            w_gnt_nxt = 2'b10;
            if (r_state != ST_GRANT1) w_last_nxt = 1'b1;
            if (req[1]) w_disp_nxt = '{digits: frame1, dp: dp1};
         end
         default: begin
            w_disp_nxt = IDLE_DISP;
         end
      endcase
   end

   // Output registers; last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt  <= 2'b00;
         r_last <= 1'b1;
         r_disp <= IDLE_DISP;
      end else begin
         r_gnt  <= w_gnt_nxt;
         r_last <= w_last_nxt;
         r_disp <= w_disp_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign dp        = r_disp.dp;
   assign hold_done = w_hold_done;
   assign d0        = r_disp.digits[0*DIGIT_W +: DIGIT_W];
   assign d1        = r_disp.digits[1*DIGIT_W +: DIGIT_W];
   assign d2        = r_disp.digits[2*DIGIT_W +: DIGIT_W];
   assign d3        = r_disp.digits[3*DIGIT_W +: DIGIT_W];
   assign d4        = r_disp.digits[4*DIGIT_W +: DIGIT_W];
   assign d5        = r_disp.digits[5*DIGIT_W +: DIGIT_W];
   assign d6        = r_disp.digits[6*DIGIT_W +: DIGIT_W];
   assign d7        = r_disp.digits[7*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// tb_sevenseg_arbiter: directed scoreboard bench for sevenseg_arbiter with
// the short simulation hold count (top_cnt = 8, 9-cycle minimum grant).
module tb_sevenseg_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req;
   logic [39:0] frame0;
   logic [39:0] frame1;
   logic [7:0]  dp0;
   logic [7:0]  dp1;
   logic [1:0]  gnt;
   logic [4:0]  d0, d1, d2, d3, d4, d5, d6, d7;
   logic [7:0]  dp;
   logic        hold_done;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  gnt;
      logic [39:0] dig;
      logic [7:0]  dp;
      logic        hd;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   logic [39:0] idle_f;
   logic [39:0] f7, f3, f4, fa, fb;

   sevenseg_arbiter #(
      .CLK_FREQUENCY_HZ  (100000000),
      .HOLD_MS           (250),
      .CNTR_WIDTH        (32),
      .SIMULATE          (1),
      .SIMULATE_HOLD_CNT (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .frame0    (frame0),
      .frame1    (frame1),
      .dp0       (dp0),
      .dp1       (dp1),
      .gnt       (gnt),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .d4        (d4),
      .d5        (d5),
      .d6        (d6),
      .d7        (d7),
      .dp        (dp),
      .hold_done (hold_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [39:0] make_frame(input int base);
      logic [39:0] f;
      for (int i = 0; i < 8; i++) f[i*5 +: 5] = 5'(base + i);
      return f;
   endfunction

   task automatic cmp(input string nm, input logic [1:0] eg, input logic [39:0] ed,
                      input logic [7:0] ep, input logic eh);
      logic [39:0] got_d;
      got_d = {d7, d6, d5, d4, d3, d2, d1, d0};
      n_vec++;
      if (gnt !== eg || got_d !== ed || dp !== ep || hold_done !== eh) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got gnt=%b dig=%h dp=%h hd=%b, want gnt=%b dig=%h dp=%h hd=%b",
                  nm, cyc, gnt, got_d, dp, hold_done, eg, ed, ep, eh);
      end
   endtask

   task automatic push(input int dc, input logic [1:0] eg, input logic [39:0] ed,
                       input logic [7:0] ep, input logic eh, input string nm);
      exp_t e;
      e.cyc = cyc + dc;
      e.gnt = eg;
      e.dig = ed;
      e.dp  = ep;
      e.hd  = eh;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compare every expectation whose cycle has arrived.
   always @(negedge clk) begin : monitor
      exp_t  e;
      string nm;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (e.cyc < cyc) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: expectation for cyc %0d missed, now cyc %0d", nm, e.cyc, cyc);
         end else begin
            cmp(nm, e.gnt, e.dig, e.dp, e.hd);
         end
      end
   end

   initial begin
`ifdef SEVENSEG_ARB_IDLE_DASH_EN
      idle_f = {8{5'd22}};
`else
      idle_f = {8{5'd23}};
`endif
      f7 = {8{5'd7}};
      f3 = {8{5'd3}};
      f4 = {8{5'd4}};
      fa = make_frame(0);
      fb = make_frame(10);

      reset = 1'b0; req = 2'b00;
      frame0 = '0; frame1 = '0; dp0 = '0; dp1 = '0;
      repeat (2) @(negedge clk);
      cmp("rst_state", 2'b00, idle_f, 8'h00, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // A: single requester, hold expiry, live frame update, drop to idle
      req = 2'b01; frame0 = f7; dp0 = 8'h81;
      push(1,  2'b01, f7, 8'h81, 1'b0, "a_grant");
      push(8,  2'b01, f7, 8'h81, 1'b0, "a_hold_run");
      push(9,  2'b01, f7, 8'h81, 1'b1, "a_hold_done");
      push(10, 2'b01, f7, 8'h81, 1'b1, "a_stay_sat");
      repeat (10) @(negedge clk);
      frame0 = f3;
      push(1, 2'b01, f3, 8'h81, 1'b1, "a_frame_upd");
      repeat (2) @(negedge clk);
      req = 2'b00;
      push(1, 2'b00, idle_f, 8'h00, 1'b0, "a_idle");
      repeat (3) @(negedge clk);

      // B: reset pulse, then both requesting alternate every 9 cycles
      reset = 1'b0;
      #1 cmp("b_rst_pulse", 2'b00, idle_f, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1; req = 2'b11;
      frame0 = fa; dp0 = 8'h01; frame1 = fb; dp1 = 8'h0F;
      push(1,  2'b01, fa, 8'h01, 1'b0, "b_g0_first");
      push(9,  2'b01, fa, 8'h01, 1'b1, "b_g0_done");
      push(10, 2'b10, fb, 8'h0F, 1'b0, "b_g1");
      push(18, 2'b10, fb, 8'h0F, 1'b1, "b_g1_done");
      push(19, 2'b01, fa, 8'h01, 1'b0, "b_g0_again");
      push(28, 2'b10, fb, 8'h0F, 1'b0, "b_g1_again");
      repeat (29) @(negedge clk);
      req = 2'b00;
      push(8, 2'b00, idle_f, 8'h00, 1'b0, "b_idle");
      repeat (10) @(negedge clk);

      // C: drop req[0] early with a new frame; old frame held until expiry
      req = 2'b01; frame0 = f7; dp0 = 8'h55;
      push(1, 2'b01, f7, 8'h55, 1'b0, "c_grant");
      repeat (2) @(negedge clk);
      req = 2'b00; frame0 = f3; dp0 = 8'hAA;
      push(1, 2'b01, f7, 8'h55, 1'b0, "c_keep_old");
      push(7, 2'b01, f7, 8'h55, 1'b1, "c_keep_at_done");
      push(8, 2'b00, idle_f, 8'h00, 1'b0, "c_idle_code");
      repeat (10) @(negedge clk);

      // D: hold already expired, req[1] rises -> direct switch
      req = 2'b01; frame0 = f4; dp0 = 8'h10;
      push(11, 2'b01, f4, 8'h10, 1'b1, "d_expired");
      repeat (12) @(negedge clk);
      req = 2'b11; frame1 = fb; dp1 = 8'h0F;
      push(1, 2'b10, fb, 8'h0F, 1'b0, "d_switch_no_idle");
      repeat (3) @(negedge clk);

      // E: asynchronous reset mid-GRANT1, then requester 0 wins the tie
      #2 reset = 1'b0;
      #1 cmp("e_async_rst", 2'b00, idle_f, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      push(1, 2'b01, f4, 8'h10, 1'b0, "e_g0_first");
      repeat (3) @(negedge clk);
      req = 2'b00;

      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d expectations never checked", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
